// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the scheduler state encoding and the frame timeout limit.
// Ports: none (package only).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

  // Baud ticks allowed in WAIT_DONE before a frame is abandoned.
  localparam int SCHED_TIMEOUT_TICKS = 16;
  localparam int SCHED_TMO_W         = 5;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after last_grant (wrapping).
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
// Ports: req (request vector), last_grant (previous winner index),
//        grant (one-hot winner), grant_idx (winner index), any_req (some request set).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan last_grant+1, +2, ... wrapping; the first hit wins, so the
  // previous owner is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Latency: req_ready in cycle N (IDLE), tx_start in N+1; after tx_done in M, next req_ready at M+1.
// Backpressure: one frame in flight; no grant is issued until the transmitter reports completion.
// Ports: clk, rst (sync, active-low), baud_trig, req_valid/req_data/req_ready (producer lanes),
//        tx_start/tx_data/tx_done (transmitter), grant_id, busy, timeout_err.
// Optional feature: define UART_SCHED_TIMEOUT_EN to abandon a frame after
// SCHED_TIMEOUT_TICKS baud ticks without tx_done; otherwise timeout_err is tied 0.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_trig,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  sched_state_t        state, state_nxt;
  logic [GW-1:0]       last_grant;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  logic                accept;
  logic                release_grant;
  logic [DATA_W-1:0]   lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_onehot),
    .grant_idx  (pick_idx),
    .any_req    (pick_any)
  );

  assign accept   = (state == IDLE) && pick_any;
  // Gated by rst so no producer sees an accept while the block is held in reset.
  assign req_ready = (accept && rst) ? pick_onehot : '0;
  assign tx_start  = (state == ISSUE);
  assign busy      = (state != IDLE);

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [SCHED_TMO_W-1:0] TMO_LIMIT = SCHED_TMO_W'(SCHED_TIMEOUT_TICKS);
  logic [SCHED_TMO_W-1:0] tmo_cnt;
  logic                   tmo_hit;

  // Cleared when a byte is accepted (entry to ISSUE); counts only in WAIT_DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_DONE && baud_trig) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_err = tmo_hit;
`else
  logic unused_baud;
  assign unused_baud = baud_trig;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    release_grant = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    tmo_hit       = 1'b0;
`endif
    case (state)
      IDLE:      if (pick_any) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // A completion arriving on the limit cycle takes priority over the abort.
        if (tx_done) begin
          state_nxt     = IDLE;
          release_grant = 1'b1;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (tmo_cnt == TMO_LIMIT) begin
          state_nxt     = IDLE;
          release_grant = 1'b1;
          tmo_hit       = 1'b1;
        end
`endif
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      tx_data    <= '0;
      grant_id   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data  <= lane[pick_idx];
        grant_id <= pick_idx;
      end
      if (release_grant) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NUM_REQ=4, DATA_W=8): directed scenarios
// plus randomized traffic, all compared every cycle against a transaction-level model.
// Honours UART_SCHED_TIMEOUT_EN when it is defined for the build.
module tb_uart_tx_sched;
  import uart_pkg::*;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        baud_trig = 1'b0;
  logic [3:0]  req_valid = 4'b0;
  logic [31:0] req_data = 32'b0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Model: who owns the transmitter, whether its start was issued, baud ticks waited.
  int         m_owner = -1;
  bit         m_launched = 1'b0;
  int         m_last = 3;
  logic [7:0] m_data = 8'h00;
  int         m_gid = 0;
  int         m_ticks = 0;

  int start_cyc[$];
  int start_gid[$];
  int done_cyc[$];
  int err_seen = 0;

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_trig   (baud_trig),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic int winner(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int w;
    cyc = cyc + 1;
    w = winner(req_valid, m_last);
    if (rst !== 1'b1) begin
      m_owner = -1; m_launched = 1'b0; m_last = 3; m_data = 8'h00; m_gid = 0; m_ticks = 0;
    end else if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w; m_gid = w; m_data = req_data[w*8 +: 8];
        m_launched = 1'b0; m_ticks = 0;
      end
    end else if (!m_launched) begin
      m_launched = 1'b1;
    end else if (tx_done === 1'b1) begin
      m_last = m_owner; m_owner = -1;
    end else if (TMO && m_ticks >= SCHED_TIMEOUT_TICKS) begin
      m_last = m_owner; m_owner = -1;
    end else if (baud_trig === 1'b1) begin
      m_ticks++;
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [3:0] er;
    if (chk_on) begin
      w = winner(req_valid, m_last);
      er = (m_owner < 0 && rst === 1'b1 && w >= 0) ? 4'(1 << w) : 4'b0;
      chk("req_ready", req_ready, er);
      chk("tx_start", tx_start, (m_owner >= 0 && !m_launched));
      chk("busy", busy, (m_owner >= 0));
      chk("tx_data", tx_data, m_data);
      chk("grant_id", grant_id, m_gid);
      chk("timeout_err", timeout_err,
          (TMO && m_owner >= 0 && m_launched && tx_done !== 1'b1 && m_ticks >= SCHED_TIMEOUT_TICKS));
    end
    if (tx_start === 1'b1) begin
      start_cyc.push_back(cyc);
      start_gid.push_back(int'(grant_id));
    end
    if (timeout_err === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(nm, tx_start, 1'b1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    done_cyc.push_back(cyc);
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int sbase, dbase, ebase, rate;

    tick();
    chk_on = 1'b1;
    tick();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_ready", req_ready, 4'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_err", timeout_err, 1'b0);

    // Two lanes valid after reset: lane 1 first, lane 3 next.
    rst = 1'b1;
    req_data = {8'hA3, 8'h11, 8'h55, 8'h22};
    req_valid = 4'b1010;
    #1;
    chk("t1_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    chk("t1_start", tx_start, 1'b1);
    chk("t1_data", tx_data, 8'h55);
    chk("t1_gid", grant_id, 2'd1);
    tick();
    pulse_done();
    #1;
    chk("t1_ready2", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    chk("t1_data2", tx_data, 8'hA3);
    chk("t1_gid2", grant_id, 2'd3);
    tick();
    pulse_done();

    // All lanes continuously valid for eight frames.
    sbase = start_cyc.size();
    dbase = done_cyc.size();
    req_data = $urandom;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_start("t2_wait_start");
      tick();
      repeat ($urandom_range(0, 3)) tick();
      pulse_done();
    end
    req_valid = 4'b0000;
    tick();
    chk("t2_frames", start_cyc.size() - sbase, 8);
    for (int i = 0; i < 8; i++) chk("t2_order", start_gid[sbase + i], exp_order[i]);
    for (int i = 0; i < 7; i++) chk("t2_gap", start_cyc[sbase + i + 1] - done_cyc[dbase + i], 2);

    // Stray tx_done in IDLE and ISSUE is dropped.
    req_valid = 4'b0100;
    tx_done = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    tx_done = 1'b0;
    chk("t3_busy", busy, 1'b1);
    chk("t3_gid", grant_id, 2'd2);
    repeat (3) tick();
    chk("t3_still_busy", busy, 1'b1);
    pulse_done();
    chk("t3_idle", busy, 1'b0);

    // Reset during WAIT_DONE; priority restarts at lane 0.
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t4_gid", grant_id, 2'd3);
    req_valid = 4'b1001;
    rst = 1'b0;
    tick();
    chk("t4_busy", busy, 1'b0);
    chk("t4_data", tx_data, 8'h00);
    chk("t4_gid_rst", grant_id, 2'd0);
    #1;
    chk("t4_ready_in_rst", req_ready, 4'b0000);
    rst = 1'b1;
    #1;
    chk("t4_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    chk("t4_start", tx_start, 1'b1);
    chk("t4_gid2", grant_id, 2'd0);
    tick();
    pulse_done();

    // Withheld completion: abort with the timeout feature, wait forever without it.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    ebase = err_seen;
    for (int i = 0; i < 16; i++) begin
      baud_trig = 1'b1;
      tick();
      baud_trig = 1'b0;
      tick();
      tick();
    end
    repeat (3) tick();
    chk("t5_err_count", err_seen - ebase, TMO ? 1 : 0);
    chk("t5_busy", busy, TMO ? 1'b0 : 1'b1);
    if (busy === 1'b1) pulse_done();
    req_valid = 4'b0110;
    #1;
    chk("t5_next_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk("t5_next_gid", grant_id, 2'd2);
    tick();
    pulse_done();

    // Randomized traffic with stray completions, baud ticks and occasional resets.
    for (int blk = 0; blk < 15; blk++) begin
      rate = ($urandom_range(0, 1) == 0) ? 4 : 60;
      for (int c = 0; c < 200; c++) begin
        req_valid = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
        req_data  = $urandom;
        tx_done   = ($urandom_range(0, rate - 1) == 0);
        baud_trig = $urandom_range(0, 1);
        rst       = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    rst = 1'b1;
    tx_done = 1'b0;
    req_valid = 4'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing one UART transmitter among `NUM_REQ` byte producers. Each requester offers a byte with a valid/ready handshake. The scheduler accepts one byte at a time, launches it on the transmitter with a one-cycle start pulse, and holds off further grants until the transmitter reports frame completion. It sits between the register/FIFO clients and the UART TX datapath, on the same `clk` and `baud_trig` as the RX/TX engines.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width of the UART frame payload.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `baud_trig`  in  1  one-cycle bit-rate tick, shared with the UART engines.
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane.
- `req_data`  in  NUM_REQ*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse; the byte is transferred when valid&ready.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmit; stable from the `tx_start` cycle until completion.
- `tx_done`  in  1  one-cycle pulse from the transmitter after the stop bit.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle abort pulse; present only with the macro, otherwise tied 0.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, pick the winner, pulse `req_ready[winner]`, latch `req_data` lane into `tx_data`, set `grant_id`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: assert `tx_start` for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE: on `tx_done`, update `last_grant <= grant_id`, then go to IDLE.
- Winner selection: the first set bit of `req_valid`, scanning from `last_grant+1` upward and wrapping modulo NUM_REQ.
- `last_grant` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `req_valid` is sampled only in IDLE. Deassertion in any other state has no effect.
- `req_ready` is never high outside IDLE and is never high on more than one bit.
- `tx_done` is ignored in IDLE and ISSUE; a stray pulse is dropped.
- Reset values:
  - state IDLE, `last_grant` NUM_REQ-1.
  - `req_ready` 0, `tx_start` 0, `tx_data` 0, `grant_id` 0, `busy` 0, `timeout_err` 0, timeout counter 0.
- Reset mid-frame returns the FSM to IDLE next edge. The accepted byte is discarded; no retry.

## Timing
- Acceptance to start: `req_ready` in cycle N, `tx_start` in cycle N+1, `busy` high from N+1.
- `tx_done` in cycle M gives IDLE at M+1. The earliest next `req_ready` is at M+1 (arbitration happens in IDLE combinationally on registered state) and the next `tx_start` at M+2.
- Under continuous demand from all lanes, grants rotate 0,1,2,3,0,… with no lane granted twice while another waits.
- `tx_data` and `grant_id` are registered and hold from the ISSUE cycle until the next acceptance.

## Configuration
- `UART_SCHED_TIMEOUT_EN` defined:
  - In WAIT_DONE, a 5-bit counter increments on each `baud_trig` and clears on entry to ISSUE.
  - When the counter reaches `SCHED_TIMEOUT_TICKS` (16) without `tx_done`, the block pulses `timeout_err` for one cycle, updates `last_grant`, and returns to IDLE.
  - A `tx_done` in the same cycle as the limit wins: normal completion, no error.
- Not defined: no counter, `timeout_err` tied 0, WAIT_DONE waits indefinitely.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `sched_state_t` (IDLE, ISSUE, WAIT_DONE);
  - the constant `SCHED_TIMEOUT_TICKS = 16`.
- Sub-module `rr_pick`: a purely combinational round-robin picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant, grant index, and an any-request flag.
  - The scheduler instantiates it once.

## Test plan
- After reset, `req_valid=4'b1010` with lane1=8'h55 and lane3=8'hA3 → `req_ready=4'b0010`, then `tx_start` with `tx_data=8'h55`, `grant_id=1`; after `tx_done`, lane 3 is granted with `tx_data=8'hA3`.
- All four lanes held valid for 8 frames → grant order 0,1,2,3,0,1,2,3; `tx_start` exactly 2 cycles after each `tx_done`.
- `tx_done` pulsed in IDLE and in ISSUE → ignored; FSM still waits in WAIT_DONE for the real completion.
- `rst=0` for one cycle during WAIT_DONE → `busy=0` and all outputs at reset values next edge; the next grant goes to lane 0.
- With `UART_SCHED_TIMEOUT_EN`, withhold `tx_done` → `timeout_err` pulses after the 16th `baud_trig`, FSM returns to IDLE, next grant goes to the following lane. Without the macro → `busy` stays high and `timeout_err` stays 0.
